serial_frame_rx: RTL and testbench

- Parametrised successor to the fixed PS/2-style serial-to-parallel receiver plus decoder pair.
- Accepts an asynchronous idle-high serial line and oversamples it from the single system clock.
- Deframes start / DATA_BITS data (LSB first) / optional parity / STOP_BITS stop bits, checks parity and framing, and buffers received words with their error flags in a small FIFO.
- Consumers drain the FIFO through a valid/ready handshake.

---
 rtl/serial_frame_rx_if.sv | 21 ++
 rtl/serial_frame_rx.sv | 167 ++++++++++++++++
 tb/tb_serial_frame_rx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Head-of-FIFO valid/ready bundle for serial_frame_rx.
// The receiver drives through master; a consumer attaches via slave.
interface serial_frame_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] oData;
  logic                 oParityErr;
  logic                 oFrameErr;
  logic                 oValid;
  logic                 iReady;

  modport master (
    output oData, oParityErr, oFrameErr, oValid,
    input  iReady
  );

  modport slave (
    input  oData, oParityErr, oFrameErr, oValid,
    output iReady
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Oversampling serial deframer (start/data/parity/stop) feeding a
// small word FIFO drained through a valid/ready handshake.
module serial_frame_rx #(
  parameter int CLKS_PER_BIT = 8000,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        Clock50,
  input  logic                        iReset,
  input  logic                        i1b,
  serial_frame_rx_if.master           rx,
  output logic [$clog2(FIFO_DEPTH):0] oCount,
  output logic                        oOverflow,
  output logic                        oBusy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = 4;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SLAST = BW'(STOP_BITS - 1);
  localparam logic EVEN = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 sync1_q, sync2_q;
  logic                 s_in, tick, push;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          valid, full, pop, wr;

  assign s_in = sync2_q;
  assign tick = (cnt_q == FULL_M1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!s_in) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          state_d = s_in ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d  = '0;
          data_d = {s_in, data_q[DATA_BITS-1:1]};
          if (bit_q == DLAST) begin
            bit_d   = '0;
            state_d = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          perr_d  = ((^data_q) ^ s_in) ~^ EVEN;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~s_in;
          if (bit_q == SLAST) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A push into a full FIFO is only legal when a pop frees a slot.
  assign valid = (count_q != '0);
  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop   = valid & rx.iReady;
  assign wr    = push & (~full | pop);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q + AW'(wr);
    rptr_d = rptr_q + AW'(pop);
    ovf_d  = ovf_q | (push & full & ~pop);
    if (wr) mem_d[wptr_q] = {data_d, perr_d, ferr_d};
    unique case ({wr, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock50 or negedge iReset) begin
    if (!iReset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q <= i1b;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
    end
  end

  assign rx.oData      = mem_q[rptr_q][EW-1:2];
  assign rx.oParityErr = mem_q[rptr_q][1];
  assign rx.oFrameErr  = mem_q[rptr_q][0];
  assign rx.oValid     = valid;
  assign oCount        = count_q;
  assign oOverflow     = ovf_q;
  assign oBusy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomised frame driver with a queue scoreboard and a
// handshake monitor for serial_frame_rx.
module tb_serial_frame_rx;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int PM  = 1;
  localparam int SB  = 1;
  localparam int FD  = 4;

  typedef struct packed {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line = 1'b1;
  logic rdy_man = 1'b0;
  logic rdy_rand = 1'b0;
  bit   rand_rdy = 1'b0;
  bit   mon_en = 1'b0;
  logic [$clog2(FD):0] cnt;
  logic ovf, busy;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   errors = 0;

  serial_frame_rx_if #(.DATA_BITS(DB)) rx ();

  assign rx.iReady = rand_rdy ? rdy_rand : rdy_man;

  serial_frame_rx #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_MODE(PM),
    .STOP_BITS(SB), .FIFO_DEPTH(FD)
  ) dut (
    .Clock50(clk), .iReset(rst_n), .i1b(line), .rx(rx),
    .oCount(cnt), .oOverflow(ovf), .oBusy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: expected word from the frame's content.
  task automatic model_push(input logic [DB-1:0] d, input bit bp,
                            input bit bs);
    exp_t e;
    e.d  = d;
    e.pe = (PM != 0) && bp;
    e.fe = bs;
    if (sb.size() < FD) sb.push_back(e);
  endtask

  task automatic send(input logic [DB-1:0] d, input bit bp,
                      input bit bs, input int cut);
    logic bits[$];
    bit   p;
    int   n;
    if (PM == 1) p = ($countones(d) % 2 == 0);
    else         p = ($countones(d) % 2 == 1);
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (PM != 0) bits.push_back(p ^ bp);
    for (int s = 0; s < SB; s++) bits.push_back(!(bs && s == SB - 1));
    n = (cut == 0) ? bits.size() : cut;
    for (int i = 0; i < n; i++) begin
      if (cut == 0 && i == bits.size() - 1) model_push(d, bp, bs);
      line = bits[i];
      cycles(CPB);
    end
    if (cut == 0) begin
      line = 1'b1;
      cycles(2 * CPB);
    end
  endtask

  task automatic pulse();
    rdy_man = 1'b1;
    cycles(1);
    rdy_man = 1'b0;
    cycles(1);
  endtask

  always begin
    @(posedge clk);
    #1;
    rdy_rand = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (mon_en && rst_n && rx.oValid && rx.iReady) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", {24'd0, rx.oData}, 32'hffff_ffff);
      end else begin
        mon_e = sb.pop_front();
        chk("pop_data", rx.oData, mon_e.d);
        chk("pop_perr", rx.oParityErr, mon_e.pe);
        chk("pop_ferr", rx.oFrameErr, mon_e.fe);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [DB-1:0] d;
    exp_t e;
    cycles(3);
    chk("rst_valid", rx.oValid, 0);
    chk("rst_data", rx.oData, 0);
    chk("rst_perr", rx.oParityErr, 0);
    chk("rst_ferr", rx.oFrameErr, 0);
    chk("rst_count", cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    cycles(2 * CPB);

    // First frame with stop-bit latency measurement.
    send(8'h8B, 1'b0, 1'b0, DB + 2);
    e = '{d: 8'h8B, pe: 1'b0, fe: 1'b0};
    sb.push_back(e);
    line = 1'b1;
    chk("valid_early", rx.oValid, 0);
    n = 0;
    while (!rx.oValid && n < CPB / 2 + 6) begin
      cycles(1);
      n++;
    end
    chk("valid_rise", rx.oValid, 1);
    chk("valid_latency", (n >= CPB / 2 && n <= CPB / 2 + 5), 1);
    cycles(3 * CPB - n);
    chk("t1_data", rx.oData, 8'h8B);
    chk("t1_perr", rx.oParityErr, 0);
    chk("t1_ferr", rx.oFrameErr, 0);
    chk("t1_count", cnt, 1);
    pulse();

    send(8'h8B, 1'b0, 1'b0, 0);
    send(8'h0F, 1'b0, 1'b0, 0);
    chk("t2_count", cnt, 2);
    pulse();
    chk("t2_count1", cnt, 1);
    chk("t2_head", rx.oData, 8'h0F);
    pulse();
    chk("t2_valid", rx.oValid, 0);
    chk("t2_sb", sb.size(), 0);

    send(8'h61, 1'b1, 1'b0, 0);
    chk("t3_data", rx.oData, 8'h61);
    chk("t3_perr", rx.oParityErr, 1);
    chk("t3_ferr", rx.oFrameErr, 0);
    pulse();

    send(8'h8B, 1'b0, 1'b1, 0);
    chk("t4_ferr", rx.oFrameErr, 1);
    chk("t4_perr", rx.oParityErr, 0);
    chk("t4_count", cnt, 1);
    pulse();
    send(8'hC4, 1'b0, 1'b0, 0);
    chk("t4_next", rx.oData, 8'hC4);
    pulse();

    // Short low pulse must be rejected at the start-bit centre.
    line = 1'b0;
    cycles(CPB / 4);
    line = 1'b1;
    cycles(CPB);
    chk("glitch_busy", busy, 0);
    chk("glitch_count", cnt, 0);

    for (int i = 0; i < FD + 1; i++) begin
      d = DB'($urandom);
      send(d, 1'b0, 1'b0, 0);
    end
    chk("ovf_count", cnt, FD);
    chk("ovf_flag", ovf, 1);
    rdy_man = 1'b1;
    cycles(2 * FD);
    rdy_man = 1'b0;
    chk("ovf_drained", cnt, 0);
    chk("ovf_sb", sb.size(), 0);
    chk("ovf_sticky", ovf, 1);
    send(8'h5A, 1'b0, 1'b0, 0);
    send(8'hA5, 1'b0, 1'b0, 5);
    rst_n = 1'b0;
    line = 1'b1;
    #1;
    chk("rst2_ovf", ovf, 0);
    chk("rst2_count", cnt, 0);
    chk("rst2_valid", rx.oValid, 0);
    chk("rst2_busy", busy, 0);
    sb.delete();
    cycles(2);
    rst_n = 1'b1;
    cycles(2 * CPB);

    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = DB'($urandom);
      send(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 0);
    end
    rand_rdy = 1'b0;
    cycles(1);
    rdy_man = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      cycles(1);
      n++;
    end
    cycles(2);
    chk("final_sb", sb.size(), 0);
    chk("final_count", cnt, 0);
    chk("final_ovf", ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
